// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// Two-stage pipeline (issue, result) with per-requester result backpressure.
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ALUOP_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*32-1:0]      req_a,
    input  logic [NUM_REQ*32-1:0]      req_b,
    input  logic [NUM_REQ*ALUOP_W-1:0] req_aluop,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [31:0]                rsp_f,
    output logic [31:0]                alu_a,
    output logic [31:0]                alu_b,
    output logic [ALUOP_W-1:0]         alu_aluop,
    input  logic [31:0]                alu_f
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic               iss_v_q, iss_v_d;
    logic [IDW-1:0]     iss_id_q, iss_id_d;
    logic [31:0]        iss_a_q, iss_a_d;
    logic [31:0]        iss_b_q, iss_b_d;
    logic [ALUOP_W-1:0] iss_op_q, iss_op_d;
    logic               res_v_q, res_v_d;
    logic [IDW-1:0]     res_id_q, res_id_d;
    logic [31:0]        res_f_q, res_f_d;
    logic [IDW-1:0]     last_q, last_d;

    logic               drain, adv, acc_ok, accept, found;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     win_id;
    int                 idx;

    assign drain  = res_v_q && rsp_ready[res_id_q];
    assign adv    = !res_v_q || drain;
    // Reset also blocks acceptance so no request is handshaken and then lost.
    assign acc_ok = !rst && !flush && (!iss_v_q || adv);

    always_comb begin
        grant  = '0;
        win_id = last_q;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!found && acc_ok && req_valid[idx]) begin
                grant[idx] = 1'b1;
                win_id     = IDW'(idx);
                found      = 1'b1;
            end
        end
    end

    assign accept    = found;
    assign req_ready = grant;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            rsp_valid[i] = res_v_q && (res_id_q == IDW'(i));
    end

    assign rsp_f     = res_f_q;
    assign alu_a     = iss_a_q;
    assign alu_b     = iss_b_q;
    assign alu_aluop = iss_op_q;

    always_comb begin
        iss_v_d  = iss_v_q;
        iss_id_d = iss_id_q;
        iss_a_d  = iss_a_q;
        iss_b_d  = iss_b_q;
        iss_op_d = iss_op_q;
        res_v_d  = res_v_q;
        res_id_d = res_id_q;
        res_f_d  = res_f_q;
        last_d   = last_q;
        if (accept) begin
            iss_v_d  = 1'b1;
            iss_id_d = win_id;
            iss_a_d  = req_a[32*int'(win_id) +: 32];
            iss_b_d  = req_b[32*int'(win_id) +: 32];
            iss_op_d = req_aluop[ALUOP_W*int'(win_id) +: ALUOP_W];
            last_d   = win_id;
        end else if (adv) begin
            iss_v_d = 1'b0;
        end
        if (adv) begin
            res_v_d  = iss_v_q;
            res_id_d = iss_id_q;
            res_f_d  = alu_f;
        end
        if (flush) begin
            iss_v_d = 1'b0;
            res_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_v_q  <= 1'b0;
            iss_id_q <= '0;
            iss_a_q  <= '0;
            iss_b_q  <= '0;
            iss_op_q <= '0;
            res_v_q  <= 1'b0;
            res_id_q <= '0;
            res_f_q  <= '0;
            last_q   <= IDW'(NUM_REQ - 1);
        end else begin
            iss_v_q  <= iss_v_d;
            iss_id_q <= iss_id_d;
            iss_a_q  <= iss_a_d;
            iss_b_q  <= iss_b_d;
            iss_op_q <= iss_op_d;
            res_v_q  <= res_v_d;
            res_id_q <= res_id_d;
            res_f_q  <= res_f_d;
            last_q   <= last_d;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: sources push expected results on accept,
// a negedge monitor pops and compares on each response handshake.
module tb_alu_arbiter;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLT = 4'd2, OP_SRA = 4'd3;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] exp;
    } txn_t;
    typedef struct {
        int          id;
        logic [31:0] f;
    } exp_t;

    logic        clk, rst, flush;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [63:0] req_a, req_b;
    logic [7:0]  req_aluop;
    logic [31:0] rsp_f, alu_a, alu_b, alu_f;
    logic [3:0]  alu_aluop;

    txn_t src0[$], src1[$];
    exp_t sb[$];
    int   gq[$];
    logic [1:0] en;
    int errors = 0, checks = 0;

    alu_arbiter #(.NUM_REQ(2), .ALUOP_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_aluop(req_aluop),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f),
        .alu_a(alu_a), .alu_b(alu_b), .alu_aluop(alu_aluop), .alu_f(alu_f)
    );

    // Reference ALU with the bench's own opcode encoding.
    always_comb begin
        case (alu_aluop)
            OP_ADD:  alu_f = alu_a + alu_b;
            OP_SUB:  alu_f = alu_a - alu_b;
            OP_SLT:  alu_f = {31'b0, $signed(alu_a) < $signed(alu_b)};
            OP_SRA:  alu_f = $signed(alu_a) >>> alu_b[4:0];
            default: alu_f = 32'd0;
        endcase
    end

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic txn_t mk(logic [31:0] a, logic [31:0] b, logic [3:0] op, logic [31:0] e);
        txn_t t;
        t.a = a; t.b = b; t.op = op; t.exp = e;
        return t;
    endfunction

    task automatic drive();
        req_valid = 2'b00;
        req_a = '0; req_b = '0; req_aluop = '0;
        if (src0.size() > 0) begin
            req_valid[0] = en[0];
            req_a[31:0] = src0[0].a; req_b[31:0] = src0[0].b; req_aluop[3:0] = src0[0].op;
        end
        if (src1.size() > 0) begin
            req_valid[1] = en[1];
            req_a[63:32] = src1[0].a; req_b[63:32] = src1[0].b; req_aluop[7:4] = src1[0].op;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        drive();
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    task automatic idle(int n);
        repeat (n) begin step(); smp(); end
    endtask

    task automatic do_reset();
        step(); rst = 1;
        step(); rst = 0;
    endtask

    task automatic chk_zero_outputs();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_f", rsp_f, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_aluop", 32'(alu_aluop), 32'd0);
    endtask

    // Monitor: responses first, then accepts, then kill on flush/reset.
    initial begin
        exp_t e;
        txn_t t;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rsp_valid != 2'b00)
                    chk("rsp_onehot", {31'b0, $onehot(rsp_valid)}, 32'd1);
                for (int i = 0; i < 2; i++) begin
                    if (rsp_valid[i] && rsp_ready[i]) begin
                        if (sb.size() == 0) begin
                            chk("rsp_unexpected", 32'(i), 32'hFFFF_FFFF);
                        end else begin
                            e = sb.pop_front();
                            chk("rsp_id", 32'(i), 32'(e.id));
                            chk("rsp_f", rsp_f, e.f);
                        end
                    end
                end
                chk("req_ready_subset", 32'(req_ready & ~req_valid), 32'd0);
                for (int i = 0; i < 2; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        gq.push_back(i);
                        if (i == 0 && src0.size() > 0) t = src0.pop_front();
                        else if (i == 1 && src1.size() > 0) t = src1.pop_front();
                        e.id = i; e.f = t.exp;
                        sb.push_back(e);
                    end
                end
            end
            if (rst || flush) sb.delete();
        end
    end

    initial begin
        rst = 1; flush = 0; rsp_ready = 2'b11; en = 2'b00;
        drive();
        repeat (2) step();
        rst = 0;
        smp();
        chk_zero_outputs();

        // Single add from requester 0: ready in c0, result in c2.
        src0.push_back(mk(32'd5, 32'd7, OP_ADD, 32'd12));
        en = 2'b01;
        step(); smp();
        chk("add_ready_c0", 32'(req_ready), 32'b01);
        step(); smp();
        chk("add_rsp_c1", 32'(rsp_valid), 32'b00);
        chk("add_alu_a", alu_a, 32'd5);
        chk("add_alu_b", alu_b, 32'd7);
        step(); smp();
        chk("add_rsp_c2", 32'(rsp_valid), 32'b01);
        chk("add_f_c2", rsp_f, 32'd12);
        step(); smp();
        chk("add_rsp_c3", 32'(rsp_valid), 32'b00);

        // Contention from reset: grants alternate 0,1,0,1,0,1.
        en = 2'b00;
        do_reset();
        src0.push_back(mk(32'hFFFF_FFFF, 32'd1, OP_SLT, 32'd1));
        src0.push_back(mk(32'd1, 32'd2, OP_ADD, 32'd3));
        src0.push_back(mk(32'd10, 32'd3, OP_SUB, 32'd7));
        src1.push_back(mk(32'h8000_0000, 32'd4, OP_SRA, 32'hF800_0000));
        src1.push_back(mk(32'd100, 32'd1, OP_ADD, 32'd101));
        src1.push_back(mk(32'd0, 32'd1, OP_SUB, 32'hFFFF_FFFF));
        gq.delete();
        en = 2'b11;
        idle(6);
        chk("cont_count", 32'(gq.size()), 32'd6);
        for (int k = 0; k < 6 && k < gq.size(); k++)
            chk("cont_grant", 32'(gq[k]), 32'(k % 2));
        en = 2'b00;
        idle(3);

        // Backpressure on requester 0.
        src0.push_back(mk(32'd1, 32'd1, OP_ADD, 32'd2));
        src0.push_back(mk(32'd2, 32'd2, OP_ADD, 32'd4));
        src0.push_back(mk(32'd3, 32'd3, OP_ADD, 32'd6));
        src0.push_back(mk(32'd4, 32'd4, OP_ADD, 32'd8));
        en = 2'b01;
        step(); rsp_ready = 2'b10; smp();
        chk("bp_ready_c0", 32'(req_ready), 32'b01);
        step(); smp();
        chk("bp_ready_c1", 32'(req_ready), 32'b01);
        repeat (3) begin
            step(); smp();
            chk("bp_ready_stall", 32'(req_ready), 32'b00);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'b01);
            chk("bp_rsp_f", rsp_f, 32'd2);
        end
        step(); rsp_ready = 2'b11; smp();
        chk("bp_release_ready", 32'(req_ready), 32'b01);
        chk("bp_release_valid", 32'(rsp_valid), 32'b01);
        idle(6);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);
        chk("bp_src_empty", 32'(src0.size()), 32'd0);

        // Pointer stays put across idle cycles.
        gq.delete();
        src1.push_back(mk(32'd10, 32'd1, OP_ADD, 32'd11));
        src1.push_back(mk(32'd20, 32'd2, OP_ADD, 32'd22));
        src1.push_back(mk(32'd30, 32'd3, OP_ADD, 32'd33));
        en = 2'b10;
        idle(3);
        en = 2'b00;
        idle(3);
        src0.push_back(mk(32'd40, 32'd4, OP_ADD, 32'd44));
        src1.push_back(mk(32'd50, 32'd5, OP_ADD, 32'd55));
        en = 2'b11;
        step(); smp();
        chk("ptr_ready", 32'(req_ready), 32'b01);
        idle(1);
        en = 2'b00;
        idle(4);
        chk("ptr_count", 32'(gq.size()), 32'd5);
        if (gq.size() == 5) begin
            chk("ptr_g0", 32'(gq[0]), 32'd1);
            chk("ptr_g3", 32'(gq[3]), 32'd0);
            chk("ptr_g4", 32'(gq[4]), 32'd1);
        end

        // Flush with two in flight; the draining result still completes.
        src0.push_back(mk(32'd5, 32'd5, OP_ADD, 32'd10));
        src0.push_back(mk(32'd6, 32'd6, OP_ADD, 32'd12));
        src0.push_back(mk(32'd7, 32'd7, OP_ADD, 32'd14));
        en = 2'b01;
        idle(2);
        step(); flush = 1; smp();
        chk("fl_ready", 32'(req_ready), 32'b00);
        chk("fl_drain", 32'(rsp_valid), 32'b01);
        step(); flush = 0; smp();
        chk("fl_rsp_c3", 32'(rsp_valid), 32'b00);
        chk("fl_ready_c3", 32'(req_ready), 32'b01);
        step(); smp();
        chk("fl_rsp_c4", 32'(rsp_valid), 32'b00);
        step(); smp();
        chk("fl_rsp_c5", 32'(rsp_valid), 32'b01);
        chk("fl_f_c5", rsp_f, 32'd14);
        en = 2'b00;
        idle(2);

        // Reset with both registers full.
        src0.push_back(mk(32'd8, 32'd8, OP_ADD, 32'd16));
        src0.push_back(mk(32'd9, 32'd9, OP_ADD, 32'd18));
        en = 2'b01;
        step(); rsp_ready = 2'b00; smp();
        idle(1);
        step(); smp();
        chk("rs_full_ready", 32'(req_ready), 32'b00);
        en = 2'b00;
        step(); rst = 1; smp();
        step(); rst = 0; rsp_ready = 2'b11; smp();
        chk_zero_outputs();
        src0.push_back(mk(32'd1, 32'd0, OP_ADD, 32'd1));
        src1.push_back(mk(32'd2, 32'd0, OP_ADD, 32'd2));
        gq.delete();
        en = 2'b11;
        step(); smp();
        chk("rs_first_grant", 32'(req_ready), 32'b01);
        idle(5);
        chk("rs_order", (gq.size() > 0) ? 32'(gq[0]) : 32'hFFFF_FFFF, 32'd0);

        en = 2'b00;
        idle(3);
        chk("end_sb_empty", 32'(sb.size()), 32'd0);
        chk("end_src_empty", 32'(src0.size() + src1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between up to four requesters (e.g. execute stage, branch-target adder, load/store address generator) through a valid/ready handshake. Round-robin arbitration selects one request per cycle, and a two-register pipeline (issue, result) sits around the ALU. Results return to the originating requester with per-requester backpressure. The block sits in the execute stage between requester pipelines and the `alu` instance, and drives its `a`, `b` and `aluop` ports.

## Interface
- `NUM_REQ`, 2, number of requesters; legal 2..4.
- `ALUOP_W`, 4, width of `rvga_aluop`.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous kill of all in-flight operations.
- `req_valid` in NUM_REQ: request valid, one bit per requester.
- `req_ready` out NUM_REQ: request accepted this cycle.
- `req_a` in NUM_REQ*32: operand a, requester i at [32i+31:32i].
- `req_b` in NUM_REQ*32: operand b, same packing.
- `req_aluop` in NUM_REQ*ALUOP_W: operation, requester i at [ALUOP_W*i+ALUOP_W-1:ALUOP_W*i].
- `rsp_valid` out NUM_REQ: result valid, one-hot or zero.
- `rsp_ready` in NUM_REQ: requester can take its result.
- `rsp_f` out 32: result word, valid for the requester flagged in `rsp_valid`.
- `alu_a` out 32: to ALU `a`.
- `alu_b` out 32: to ALU `b`.
- `alu_aluop` out ALUOP_W: to ALU `aluop`.
- `alu_f` in 32: from ALU `f`.

## Operation
- **Issue register:** `iss_v`, `iss_id`, `iss_a`, `iss_b`, `iss_op`. It drives `alu_a`, `alu_b` and `alu_aluop` directly. The ALU result is combinational in the same cycle.
- **Result register:** `res_v`, `res_id`, `res_f`.
  - `rsp_valid[i] = res_v && res_id==i`.
  - `rsp_f = res_f`.
- **Drain:** `drain = res_v && rsp_ready[res_id]`.
- **Advance:** `adv = !res_v || drain`. When `adv`, the result register loads `iss_v`, `iss_id` and `alu_f`.
- **Accept:** `acc_ok = !flush && (!iss_v || adv)`. The arbiter grants exactly one i with `req_valid[i]`, and only when `acc_ok`.
  - `req_ready[i]` = grant[i]. This output depends combinationally on `req_valid`.
  - A requester's `req_valid` must not depend on its `req_ready`.
  - Once asserted, `req_valid` and the request payload must hold until accepted.
- **On accept:** the issue register loads the winner's operands and id, and sets `iss_v`=1.
- **No accept with `adv`:** `iss_v` clears.
- **No accept without `adv`:** the issue register holds.
- **Round-robin:**
  - Pointer `last` (log2 NUM_REQ bits). Priority order is `last+1, last+2, …` modulo NUM_REQ.
  - `last` updates to the winner only on an accepted grant; it does not move on idle cycles or stalls.
- **`flush`:** `iss_v`, `res_v` ← 0 at the next edge.
  - No request is accepted in a flush cycle.
  - A result draining in the flush cycle still completes its handshake.
  - `last` is unchanged.
- **Reset values:**
  - `iss_v`=0, `res_v`=0, all data/id registers 0, `last`=NUM_REQ-1 (requester 0 wins first).
  - `req_ready`=0, `rsp_valid`=0, `rsp_f`=0, `alu_a`=0, `alu_b`=0, `alu_aluop`=0.
- **Idle:** the arbiter does not interpret `aluop`. Issue-register data holds its last value when `iss_v`=0; the `res_f` captured while idle is ignored.
- **Reset mid-operation:** all in-flight operations are discarded with no response. The same applies to flush.

## Timing
- **Latency:** request accepted in cycle k (`req_valid[i]&&req_ready[i]`) → issue register valid in k+1 → `rsp_valid[i]`=1 with `rsp_f` in k+2, provided `rsp_ready` permits.
- **Throughput:** one operation per cycle when the responding requester holds `rsp_ready`=1.
- **Backpressure:**
  - `rsp_ready[res_id]`=0 stalls the result register.
  - The issue register then fills, and `req_ready` drops to all-zero in the next cycle.
  - Maximum two operations are in flight.
- **Stall recovery:** same-cycle drain and accept is legal. When `drain` occurs with both registers full, a new request is accepted that cycle with no bubble.
- **Ordering:** responses return in acceptance order.

## Test plan
- **Single add:** requester 0 sends a=5, b=7, op=add in cycle 0 → `req_ready[0]`=1 in cycle 0; `rsp_valid[0]`=1, `rsp_f`=12 in cycle 2; `rsp_valid[1]`=0 throughout.
- **Contention:** both requesters valid every cycle with `rsp_ready`=all-ones → grants alternate 0,1,0,1 from reset. Requester 1 sends sra a=0x80000000, b=4 → `rsp_f`=0xF8000000 to requester 1. Requester 0 sends slt a=0xFFFFFFFF, b=1 → 1.
- **Backpressure:** hold `rsp_ready[0]`=0 after two accepts → `req_ready` is all-zero from the next cycle, and `rsp_f` is stable. Release → the first result drains, a new accept happens the same cycle, order is preserved, and there are no lost or duplicated results.
- **Pointer stability:** only requester 1 is valid for 3 accepts, then both are valid → requester 0 wins next.
- **Flush:** with two operations in flight, assert `flush` for one cycle while `req_valid[0]`=1 → `req_ready`=0 in that cycle, no `rsp_valid` afterwards for the killed operations, and the next accept has 2-cycle latency.
- **Reset mid-stream:** assert `rst` with both registers full → all outputs 0 on the next cycle, and requester 0 wins the first post-reset grant.
